// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter: the winner may hold a one-hot grant for up to
// its latched quota of cycles before the search rotates past it.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   S_IDLE  | no requester granted, grant/grant_id are zero
//   S_GRANT | grant_q holds the current burst owner ptr_q
module arbiter_wrr #(
  parameter int VECTOR_IN = 8,
  parameter int WEIGHT_W  = 4,
  localparam int IDW      = $clog2(VECTOR_IN)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic [VECTOR_IN-1:0]          request_vector,
  input  logic [VECTOR_IN*WEIGHT_W-1:0] weight,
  output logic [VECTOR_IN-1:0]          grant,
  output logic                          grant_valid,
  output logic [IDW-1:0]                grant_id,
  output logic                          burst_last
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t               state_q, state_d;
  logic [VECTOR_IN-1:0] grant_q, grant_d;
  logic [IDW-1:0]       grant_id_q, grant_id_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]  cnt_q, cnt_d;
  logic [WEIGHT_W-1:0]  q_q, q_d;

  logic                 found;
  logic [IDW-1:0]       win_idx;
  logic [WEIGHT_W-1:0]  win_weight;
  logic [WEIGHT_W-1:0]  q_eff;
  logic                 keep;

  // Search starts just past the last winner, so the holder itself is checked last.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= VECTOR_IN; k++) begin
      if (!found && request_vector[(int'(ptr_q) + k) % VECTOR_IN]) begin
        found   = 1'b1;
        win_idx = IDW'((int'(ptr_q) + k) % VECTOR_IN);
      end
    end
  end

  assign win_weight = weight[int'(win_idx)*WEIGHT_W +: WEIGHT_W];
  assign q_eff      = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
  assign keep       = (state_q == S_GRANT) && request_vector[ptr_q] &&
                      (({1'b0, cnt_q} + 1'b1) < {1'b0, q_q});

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    if (!stall) begin
      if (keep) begin
        cnt_d = cnt_q + 1'b1;
      end else if (found) begin
        state_d          = S_GRANT;
        grant_d          = '0;
        grant_d[win_idx] = 1'b1;
        grant_id_d       = win_idx;
        ptr_d            = win_idx;
        cnt_d            = '0;
        q_d              = q_eff;
      end else begin
        // ptr is kept so rotation resumes where it left off
        state_d    = S_IDLE;
        grant_d    = '0;
        grant_id_d = '0;
        cnt_d      = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= IDW'(VECTOR_IN - 1);
      cnt_q      <= '0;
      q_q        <= WEIGHT_W'(1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = (state_q == S_GRANT);
  assign grant_id    = grant_id_q;
  assign burst_last  = grant_valid && (cnt_q == (q_q - 1'b1));

endmodule
